// File: rtl/obstacle_scroller_if.sv
// Game-mode input and per-slot obstacle geometry shared between the scroller
// and its consumers (collision stage, renderer).
interface obstacle_scroller_if #(
  parameter int unsigned SLOTS = 10
);
  logic [1:0]             gamemode;
  logic [SLOTS-1:0][9:0]  obstacle_x_left;
  logic [SLOTS-1:0][2:0]  obstacle_x_length;
  logic [SLOTS-1:0][8:0]  obstacle_y_up;
  logic [SLOTS-1:0][2:0]  obstacle_y_length;
  logic [SLOTS-1:0]       obstacle_active;
  logic [3:0]             scroll_speed;
  logic [15:0]            obstacles_passed;

  modport master (
    input  gamemode,
    output obstacle_x_left, obstacle_x_length, obstacle_y_up, obstacle_y_length,
           obstacle_active, scroll_speed, obstacles_passed
  );

  modport slave (
    output gamemode,
    input  obstacle_x_left, obstacle_x_length, obstacle_y_up, obstacle_y_length,
           obstacle_active, scroll_speed, obstacles_passed
  );
endinterface

// File: rtl/obstacle_scroller.sv
// Per-frame obstacle spawner/scroller: spawns LFSR-shaped obstacles at the right
// edge, scrolls them left, retires them at x=0 and ramps scroll speed over time.
module obstacle_scroller #(
  parameter int unsigned SLOTS          = 10,
  parameter int unsigned UNIT_LENGTH    = 30,
  parameter int unsigned SPAWN_X        = 640,
  parameter int unsigned UPPER_BOUND    = 20,
  parameter int unsigned SPAWN_INTERVAL = 45,
  parameter int unsigned INIT_SPEED     = 4,
  parameter int unsigned MAX_SPEED      = 8,
  parameter int unsigned RAMP_INTERVAL  = 600,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  obstacle_scroller_if.master bus
);

  localparam int unsigned SPAWN_W = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
  localparam int unsigned RAMP_W  = (RAMP_INTERVAL > 1) ? $clog2(RAMP_INTERVAL) : 1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    MODE_CLEAR = 2'b00,
    MODE_PLAY  = 2'b01,
    MODE_PAUSE = 2'b10,
    MODE_OVER  = 2'b11
  } mode_e;

  mode_e w_mode;

  logic [SLOTS-1:0][9:0] r_x_left,  w_x_left;
  logic [SLOTS-1:0][2:0] r_x_len,   w_x_len;
  logic [SLOTS-1:0][8:0] r_y_up,    w_y_up;
  logic [SLOTS-1:0][2:0] r_y_len,   w_y_len;
  logic [SLOTS-1:0]      r_active,  w_active;
  logic [3:0]            r_speed,   w_speed;
  logic [15:0]           r_passed,  w_passed;
  logic [SPAWN_W-1:0]    r_spawn_timer, w_spawn_timer;
  logic [RAMP_W-1:0]     r_ramp_cnt,    w_ramp_cnt;
  logic [15:0]           r_lfsr,    w_lfsr;

  logic [SLOTS-1:0]      w_retire;
  logic [15:0]           w_retire_cnt;
  logic                  w_spawn;
  logic                  w_taken;
  logic [2:0]            w_new_xlen;
  logic [2:0]            w_new_ylen;
  logic [3:0]            w_row;
  logic [8:0]            w_new_y_up;
  logic [15:0]           w_lfsr_next;

  assign w_mode = mode_e'(bus.gamemode);

  // Spawn geometry and LFSR successor derived from the current LFSR value
  always_comb begin
    w_new_ylen  = 3'd1 + 3'(r_lfsr[5:4]);
    w_new_xlen  = 3'd1 + 3'(r_lfsr[7:6]);
    w_row       = r_lfsr[3:0];
    if (5'(r_lfsr[3:0]) > (5'd14 - 5'(w_new_ylen))) begin
      w_row = r_lfsr[3:0] - 4'd8;
    end
    w_new_y_up  = 9'(UPPER_BOUND) + 9'(w_row) * 9'(UNIT_LENGTH);
    w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
  end

  // Next-state: move, retire, spawn and ramp, all from pre-edge registers
  always_comb begin
    w_x_left      = r_x_left;
    w_x_len       = r_x_len;
    w_y_up        = r_y_up;
    w_y_len       = r_y_len;
    w_active      = r_active;
    w_speed       = r_speed;
    w_passed      = r_passed;
    w_spawn_timer = r_spawn_timer;
    w_ramp_cnt    = r_ramp_cnt;
    w_lfsr        = r_lfsr;
    w_retire      = '0;
    w_retire_cnt  = '0;
    w_spawn       = 1'b0;
    w_taken       = 1'b0;

    if (w_mode == MODE_PLAY) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (r_active[i]) begin
          if (r_x_left[i] >= 10'(r_speed)) begin
            w_x_left[i] = r_x_left[i] - 10'(r_speed);
          end else begin
            w_retire[i] = 1'b1;
            w_active[i] = 1'b0;
            w_x_left[i] = '0;
            w_x_len[i]  = '0;
            w_y_up[i]   = '0;
            w_y_len[i]  = '0;
          end
        end
        w_retire_cnt = w_retire_cnt + 16'(w_retire[i]);
      end
      w_passed = r_passed + w_retire_cnt;

      if (r_spawn_timer == SPAWN_W'(SPAWN_INTERVAL - 1)) begin
        w_spawn_timer = '0;
        w_spawn       = 1'b1;
        w_lfsr        = w_lfsr_next;
      end else begin
        w_spawn_timer = r_spawn_timer + SPAWN_W'(1);
      end

      // Lowest-index slot free before the edge; a retiring slot was active so is skipped
      for (int i = 0; i < SLOTS; i++) begin
        if (w_spawn && !w_taken && !r_active[i]) begin
          w_taken     = 1'b1;
          w_active[i] = 1'b1;
          w_x_left[i] = 10'(SPAWN_X);
          w_x_len[i]  = w_new_xlen;
          w_y_up[i]   = w_new_y_up;
          w_y_len[i]  = w_new_ylen;
        end
      end

      if (r_ramp_cnt == RAMP_W'(RAMP_INTERVAL - 1)) begin
        w_ramp_cnt = '0;
        if (r_speed < 4'(MAX_SPEED)) begin
          w_speed = r_speed + 4'd1;
        end
      end else begin
        w_ramp_cnt = r_ramp_cnt + RAMP_W'(1);
      end
    end
  end

  // State register; clear mode behaves like reset so each game replays the same sequence
  always_ff @(posedge clk) begin
    if (rst || (w_mode == MODE_CLEAR)) begin
      r_x_left      <= '0;
      r_x_len       <= '0;
      r_y_up        <= '0;
      r_y_len       <= '0;
      r_active      <= '0;
      r_speed       <= 4'(INIT_SPEED);
      r_passed      <= '0;
      r_spawn_timer <= '0;
      r_ramp_cnt    <= '0;
      r_lfsr        <= LFSR_SEED;
    end else begin
      r_x_left      <= w_x_left;
      r_x_len       <= w_x_len;
      r_y_up        <= w_y_up;
      r_y_len       <= w_y_len;
      r_active      <= w_active;
      r_speed       <= w_speed;
      r_passed      <= w_passed;
      r_spawn_timer <= w_spawn_timer;
      r_ramp_cnt    <= w_ramp_cnt;
      r_lfsr        <= w_lfsr;
    end
  end

  assign bus.obstacle_x_left   = r_x_left;
  assign bus.obstacle_x_length = r_x_len;
  assign bus.obstacle_y_up     = r_y_up;
  assign bus.obstacle_y_length = r_y_len;
  assign bus.obstacle_active   = r_active;
  assign bus.scroll_speed      = r_speed;
  assign bus.obstacles_passed  = r_passed;

endmodule

// File: tb/tb_obstacle_scroller.sv
// Directed bench: default-parameter scroller for spawn/scroll/pause/ramp/clear,
// and a fast-spawn instance for slot exhaustion and dropped spawns.
module tb_obstacle_scroller;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  obstacle_scroller_if #(.SLOTS(10)) bus_a ();
  obstacle_scroller_if #(.SLOTS(10)) bus_b ();

  obstacle_scroller #(.SLOTS(10)) u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  obstacle_scroller #(
    .SLOTS(10), .SPAWN_INTERVAL(1), .INIT_SPEED(1), .RAMP_INTERVAL(60000)
  ) u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] l, input int n);
    logic [15:0] v;
    v = l;
    for (int k = 0; k < n; k++) v = (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    return v;
  endfunction

  function automatic int exp_yup(input logic [15:0] l);
    int yl;
    int r;
    yl = 1 + int'(l[5:4]);
    r  = int'(l[3:0]);
    if (r > 14 - yl) r = r - 8;
    return 20 + r * 30;
  endfunction

  initial begin
    logic [15:0] l642;
    logic [15:0] l9;

    // ---------------- DUT A: default parameters ----------------
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.gamemode = 2'b01;
    bus_b.gamemode = 2'b10;
    tick(2);
    rst_a = 1'b0;
    check_eq("rst_active",  32'(bus_a.obstacle_active), 0);
    check_eq("rst_xl_any",  32'(|bus_a.obstacle_x_left), 0);
    check_eq("rst_yu_any",  32'(|bus_a.obstacle_y_up), 0);
    check_eq("rst_len_any", 32'(|bus_a.obstacle_x_length | |bus_a.obstacle_y_length), 0);
    check_eq("rst_speed",   32'(bus_a.scroll_speed), 4);
    check_eq("rst_passed",  32'(bus_a.obstacles_passed), 0);

    tick(44);  // play edge 44
    check_eq("e44_active", 32'(bus_a.obstacle_active), 0);
    tick(1);   // 45
    check_eq("e45_active", 32'(bus_a.obstacle_active), 1);
    check_eq("e45_xl0",    32'(bus_a.obstacle_x_left[0]), 640);
    check_eq("e45_xlen0",  32'(bus_a.obstacle_x_length[0]), 4);
    check_eq("e45_ylen0",  32'(bus_a.obstacle_y_length[0]), 3);
    check_eq("e45_yup0",   32'(bus_a.obstacle_y_up[0]), 50);

    tick(45);  // 90: second spawn uses LFSR 16'hE270
    check_eq("e90_xl0",   32'(bus_a.obstacle_x_left[0]), 460);
    check_eq("e90_xl1",   32'(bus_a.obstacle_x_left[1]), 640);
    check_eq("e90_yup1",  32'(bus_a.obstacle_y_up[1]), 20);
    check_eq("e90_ylen1", 32'(bus_a.obstacle_y_length[1]), 4);
    check_eq("e90_xlen1", 32'(bus_a.obstacle_x_length[1]), 2);

    tick(10);  // 100
    check_eq("e100_xl0", 32'(bus_a.obstacle_x_left[0]), 420);
    bus_a.gamemode = 2'b10;
    tick(20);
    check_eq("pause_xl0",    32'(bus_a.obstacle_x_left[0]), 420);
    check_eq("pause_xl1",    32'(bus_a.obstacle_x_left[1]), 600);
    check_eq("pause_active", 32'(bus_a.obstacle_active), 3);
    check_eq("pause_speed",  32'(bus_a.scroll_speed), 4);
    bus_a.gamemode = 2'b01;
    tick(1);   // 101
    check_eq("e101_xl0", 32'(bus_a.obstacle_x_left[0]), 416);
    tick(33);  // 134: spawn timer resumed where it stopped
    check_eq("e134_active", 32'(bus_a.obstacle_active), 3);
    tick(1);   // 135
    check_eq("e135_active", 32'(bus_a.obstacle_active), 7);

    tick(70);  // 205
    check_eq("e205_xl0",  32'(bus_a.obstacle_x_left[0]), 0);
    check_eq("e205_act0", 32'(bus_a.obstacle_active[0]), 1);
    check_eq("e205_pass", 32'(bus_a.obstacles_passed), 0);
    tick(1);   // 206
    check_eq("e206_act0",  32'(bus_a.obstacle_active[0]), 0);
    check_eq("e206_xlen0", 32'(bus_a.obstacle_x_length[0]), 0);
    check_eq("e206_yup0",  32'(bus_a.obstacle_y_up[0]), 0);
    check_eq("e206_pass",  32'(bus_a.obstacles_passed), 1);
    check_eq("e206_xl1",   32'(bus_a.obstacle_x_left[1]), 176);

    tick(393); // 599
    check_eq("e599_speed", 32'(bus_a.scroll_speed), 4);
    tick(1);   // 600
    check_eq("e600_speed", 32'(bus_a.scroll_speed), 5);
    tick(1799);// 2399
    check_eq("e2399_speed", 32'(bus_a.scroll_speed), 7);
    tick(1);   // 2400
    check_eq("e2400_speed", 32'(bus_a.scroll_speed), 8);
    tick(600); // 3000
    check_eq("e3000_speed", 32'(bus_a.scroll_speed), 8);

    bus_a.gamemode = 2'b00;
    tick(1);
    check_eq("clr_active", 32'(bus_a.obstacle_active), 0);
    check_eq("clr_xl_any", 32'(|bus_a.obstacle_x_left), 0);
    check_eq("clr_speed",  32'(bus_a.scroll_speed), 4);
    check_eq("clr_passed", 32'(bus_a.obstacles_passed), 0);
    bus_a.gamemode = 2'b01;
    tick(45);
    check_eq("replay_active", 32'(bus_a.obstacle_active), 1);
    check_eq("replay_yup0",   32'(bus_a.obstacle_y_up[0]), 50);
    check_eq("replay_xlen0",  32'(bus_a.obstacle_x_length[0]), 4);
    bus_a.gamemode = 2'b10;

    // ---------------- DUT B: spawn every frame, speed 1 ----------------
    rst_b = 1'b0;
    bus_b.gamemode = 2'b01;
    tick(3);
    check_eq("b_pre_active", 32'(bus_b.obstacle_active), 7);
    bus_b.gamemode = 2'b00;
    tick(1);
    check_eq("b_clr_active", 32'(bus_b.obstacle_active), 0);
    check_eq("b_clr_speed",  32'(bus_b.scroll_speed), 1);
    bus_b.gamemode = 2'b01;
    tick(1);   // edge 1
    check_eq("b_e1_active", 32'(bus_b.obstacle_active), 1);
    check_eq("b_e1_yup0",   32'(bus_b.obstacle_y_up[0]), 50);
    check_eq("b_e1_xl0",    32'(bus_b.obstacle_x_left[0]), 640);
    tick(8);   // 9
    check_eq("b_e9_active", 32'(bus_b.obstacle_active), 32'h1FF);
    tick(1);   // 10
    check_eq("b_e10_active", 32'(bus_b.obstacle_active), 32'h3FF);
    l9 = lfsr_adv(16'hACE1, 9);
    check_eq("b_e10_yup9",  32'(bus_b.obstacle_y_up[9]), 32'(exp_yup(l9)));
    check_eq("b_e10_ylen9", 32'(bus_b.obstacle_y_length[9]), 32'(1 + int'(l9[5:4])));
    check_eq("b_e10_xlen9", 32'(bus_b.obstacle_x_length[9]), 32'(1 + int'(l9[7:6])));
    tick(1);   // 11: spawn dropped
    check_eq("b_e11_active", 32'(bus_b.obstacle_active), 32'h3FF);
    check_eq("b_e11_xl0",    32'(bus_b.obstacle_x_left[0]), 630);
    check_eq("b_e11_xl9",    32'(bus_b.obstacle_x_left[9]), 639);
    check_eq("b_e11_yup0",   32'(bus_b.obstacle_y_up[0]), 50);
    check_eq("b_e11_yup9",   32'(bus_b.obstacle_y_up[9]), 32'(exp_yup(l9)));
    tick(631); // 642: slot 0 retires, spawn still dropped
    check_eq("b_e642_act0", 32'(bus_b.obstacle_active[0]), 0);
    check_eq("b_e642_pass", 32'(bus_b.obstacles_passed), 1);
    tick(1);   // 643: slot 0 refilled from an LFSR that advanced on every attempt
    l642 = lfsr_adv(16'hACE1, 642);
    check_eq("b_e643_act0", 32'(bus_b.obstacle_active[0]), 1);
    check_eq("b_e643_act1", 32'(bus_b.obstacle_active[1]), 0);
    check_eq("b_e643_xl0",  32'(bus_b.obstacle_x_left[0]), 640);
    check_eq("b_e643_yup0", 32'(bus_b.obstacle_y_up[0]), 32'(exp_yup(l642)));
    check_eq("b_e643_ylen0", 32'(bus_b.obstacle_y_length[0]), 32'(1 + int'(l642[5:4])));
    check_eq("b_e643_xlen0", 32'(bus_b.obstacle_x_length[0]), 32'(1 + int'(l642[7:6])));
    check_eq("b_e643_pass", 32'(bus_b.obstacles_passed), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/obstacle_scroller.md
# obstacle_scroller

Upstream obstacle source for the collision/player stage. Once per frame it spawns up to 10 pseudo-random rectangular obstacles at the right screen edge, scrolls them left, retires them at the left edge and speeds up over time. Its registered per-slot geometry (left X and top Y in pixels; width and height in 30-px units) drives collision detection and the renderer directly.

## Interface
Parameters:
- `SLOTS`, 10: obstacle slot count (outputs sized to this).
- `UNIT_LENGTH`, 30: pixels per size unit.
- `SPAWN_X`, 640: x_left of a newly spawned obstacle.
- `UPPER_BOUND`, 20: Y of row 0.
- `SPAWN_INTERVAL`, 45: play frames between spawn attempts.
- `INIT_SPEED`, 4: initial scroll, px/frame.
- `MAX_SPEED`, 8: speed ceiling.
- `RAMP_INTERVAL`, 600: play frames per +1 speed.
- `LFSR_SEED`, 16'hACE1: LFSR reset value (must be non-zero).

Ports:
- `clk`  in  1: 60 Hz frame clock; one update per edge.
- `rst`  in  1: synchronous, active-high reset.
- `gamemode`  in  2: 00 clear, 01 play, 10 pause, 11 game over.
- `obstacle_x_left`  out  [SLOTS-1:0][9:0]: left X, px.
- `obstacle_x_length`  out  [SLOTS-1:0][2:0]: width, units (0 when inactive).
- `obstacle_y_up`  out  [SLOTS-1:0][8:0]: top Y, px.
- `obstacle_y_length`  out  [SLOTS-1:0][2:0]: height, units (0 when inactive).
- `obstacle_active`  out  [SLOTS-1:0]: slot occupied.
- `scroll_speed`  out  4: current px/frame.
- `obstacles_passed`  out  16: retired-obstacle count (score), wraps at 2^16.

## Operation
- Reset state (`rst`=1, or `gamemode`=00 without `rst`): all slots inactive; all geometry outputs 0; `scroll_speed`=INIT_SPEED; spawn_timer=0; ramp_counter=0; `obstacles_passed`=0.
- LFSR reset: `rst` sets it to LFSR_SEED. `gamemode`=00 also reloads LFSR_SEED, so every new game produces the same sequence.
- Inactive slot: x_left=0, y_up=0, both lengths 0. Its right edge is 0, so it can never collide.
- Pause (10) and game over (11): every register holds.
- Play (01), in this order each edge, all decisions taken from pre-edge registered values:
  - Move: each active slot with x_left ≥ speed gets x_left −= speed.
  - Retire: each active slot with x_left < speed is cleared to the inactive values. `obstacles_passed` += number of slots retired this frame (popcount).
  - Spawn: spawn_timer increments and wraps to 0 at SPAWN_INTERVAL−1. On the wrap edge, spawn into the lowest-index slot that was inactive pre-edge.
    - A slot retiring on the same edge is not eligible.
    - No free slot: the spawn is dropped; the timer still wraps and the LFSR still advances.
- Spawn geometry from the current 16-bit LFSR value L; the LFSR advances once after each spawn attempt.
  - ylen = 1 + L[5:4] (1..4); xlen = 1 + L[7:6] (1..4).
  - row_raw = L[3:0]; row = (row_raw > 14−ylen) ? row_raw−8 : row_raw.
  - y_up = UPPER_BOUND + row·UNIT_LENGTH, so y_up + ylen·30 ≤ 440.
  - x_left = SPAWN_X. The new slot is not moved on its spawn edge.
- LFSR: 16-bit Galois, right shift, taps mask 16'hB400. Next state = (L>>1) ^ (L[0] ? 16'hB400 : 0). Never reaches 0.
- Speed ramp: ramp_counter counts play frames and wraps at RAMP_INTERVAL−1. On the wrap, speed += 1 if speed < MAX_SPEED. The new speed applies from the next edge.
- Width rules:
  - x_left arithmetic is 10-bit unsigned and cannot underflow, because of the retire rule.
  - row·30 fits in 9 bits.
  - `obstacles_passed` is 16-bit modulo.

## Timing
- All outputs are registered; every output change is visible one edge after the decision edge.
- First spawn: on play edge #45 (timer 44→0); the slot is visible after that edge.
- An obstacle reaching x_left=0 retires on the following play edge.
- Mid-game `rst` or `gamemode`=00 clears everything on that edge, overriding a spawn or retire in flight.
- `gamemode` changes take effect on the same edge they are sampled.

## Test plan
- Reset: assert `rst` 2 cycles, then hold `gamemode`=01 → all outputs 0 except `scroll_speed`=4. After play edge 45: slot 0 active, x_left=640, x_length=4, y_length=3, y_up=50 (seed 16'hACE1).
- Scroll/retire: continue play → slot 0 x_left = 640−4n after n further edges; reaches 0 at edge 205; after edge 206 slot 0 is inactive and `obstacles_passed`=1.
- Pause: `gamemode`=10 for 20 edges mid-scroll → every output and internal counter frozen; resuming 01 continues exactly where it stopped.
- Full slots: force SPAWN_INTERVAL=1, INIT_SPEED=1 → slots 0..9 fill on edges 1..10; edge 11 spawn is dropped, no slot is overwritten, and the LFSR still advances.
- Ramp: 600 play edges → `scroll_speed`=5. After 2400 edges → 8, and it stays 8 at 3000.
- Clear mid-game: `gamemode`=00 for one edge with 3 active slots → all slots inactive, speed 4, score 0. Returning to 01 reproduces the identical first spawn (y_up=50).
